// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one external N-bit ALU
// between two requesters. Optional grant counters: ALU_SHARE_STATS_EN.
module alu_share_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_s0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,
    input  logic [N-1:0] req_s1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [N-1:0] resp_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [N-1:0] alu_s,
    input  logic [N-1:0] alu_out
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gnt;
    logic   win;
    logic   any_req;

    // Round-robin pick: on a tie the requester that did not win last time goes
    always_comb begin
        any_req = |req_valid;
        win     = 1'b0;
        if (req_valid == 2'b11) begin
            win = ~last_grant;
        end else if (req_valid[1]) begin
            win = 1'b1;
        end
    end

    // Accept is offered only in IDLE, and never while reset is held
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state == IDLE && any_req) begin
            req_ready = win ? 2'b10 : 2'b01;
        end
    end

    // Controller FSM: latch operands, wait one cycle for the ALU, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            resp_valid <= 2'b00;
            resp_data  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_a      <= win ? req_a1 : req_a0;
                        alu_b      <= win ? req_b1 : req_b0;
                        alu_s      <= win ? req_s1 : req_s0;
                        gnt        <= win;
                        last_grant <= win;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_out;
                    resp_valid <= gnt ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[gnt]) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 2'b00;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_STATS_EN
    logic accept;
    assign accept = (state == IDLE) && any_req;

    // Saturating count of accepted requests per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!win && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (win && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: vector table, hand sequences and a
// randomized run against a transaction-level model; external ALU modelled here.
module tb_alu_share_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0, req_b0, req_s0;
    logic [N-1:0] req_a1, req_b1, req_s1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [N-1:0] resp_data;
    logic [N-1:0] alu_a, alu_b, alu_s;
    logic [N-1:0] alu_out;
`ifdef ALU_SHARE_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic m_last;
    int   m_cnt0;
    int   m_cnt1;

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu_f(
        input logic [N-1:0] a, b, s);
        case (s)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_s);

    alu_share_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_s0     (req_s0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_s1     (req_s1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_out    (alu_out)
`ifdef ALU_SHARE_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    task automatic check(input string name,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: offer, accept, exec, optional stall, handshake
    task automatic op(input logic [1:0] v,
                      input logic [N-1:0] a0, b0, s0,
                      input logic [N-1:0] a1, b1, s1,
                      input int stall,
                      input logic eg,
                      input logic [N-1:0] ed);
        logic [1:0]   oh;
        logic [N-1:0] ea, eb, es;
        int           n;
        oh = eg ? 2'b10 : 2'b01;
        ea = eg ? a1 : a0;
        eb = eg ? b1 : b0;
        es = eg ? s1 : s0;
        req_valid  = v;
        req_a0 = a0; req_b0 = b0; req_s0 = s0;
        req_a1 = a1; req_b1 = b1; req_s1 = s1;
        resp_ready = 2'b00;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            check("ready_timeout", 16'(n), 16'd0);
        end
        check("req_ready_grant", 16'(req_ready), 16'(oh));
        tick();
        req_valid[eg] = 1'b0;
        check("alu_a_latched", 16'(alu_a), 16'(ea));
        check("alu_b_latched", 16'(alu_b), 16'(eb));
        check("alu_s_latched", 16'(alu_s), 16'(es));
        check("exec_resp_valid", 16'(resp_valid), 16'd0);
        check("exec_req_ready", 16'(req_ready), 16'd0);
        tick();
        check("resp_valid", 16'(resp_valid), 16'(oh));
        check("resp_data", 16'(resp_data), 16'(ed));
        for (int i = 0; i < stall; i++) begin
            resp_ready = ~oh;
            tick();
            check("stall_resp_valid", 16'(resp_valid), 16'(oh));
            check("stall_resp_data", 16'(resp_data), 16'(ed));
            check("stall_req_ready", 16'(req_ready), 16'd0);
        end
        resp_ready = oh;
        tick();
        resp_ready = 2'b00;
        check("resp_done", 16'(resp_valid), 16'd0);
        check("alu_a_hold", 16'(alu_a), 16'(ea));
        m_last = eg;
        if (eg) begin
            if (m_cnt1 < 65535) m_cnt1++;
        end else begin
            if (m_cnt0 < 65535) m_cnt0++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    typedef struct {
        logic [1:0]   v;
        logic [N-1:0] a0, b0, s0, a1, b1, s1;
        int           stall;
        logic         eg;
        logic [N-1:0] ed;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0]   rv;
        logic [N-1:0] ra0, rb0, rs0, ra1, rb1, rs1;
        logic         rg;

        vecs[0] = '{2'b01,   5,  23, 0,   0,   0, 0, 0, 1'b0,  28};
        vecs[1] = '{2'b10,   0,   0, 0, 100, 200, 0, 0, 1'b1,  44};
        vecs[2] = '{2'b11,  10,  12, 1,  24,  30, 0, 0, 1'b0, 254};
        vecs[3] = '{2'b11,  10,  12, 1,  24,  30, 0, 0, 1'b1,  54};
        vecs[4] = '{2'b11,  10,  12, 1,  24,  30, 0, 0, 1'b0, 254};
        vecs[5] = '{2'b11,  10,  12, 1,  24,  30, 0, 1, 1'b1,  54};
        vecs[6] = '{2'b01, 200, 100, 1,   0,   0, 0, 5, 1'b0, 100};
        vecs[7] = '{2'b11,   1,   1, 0,   7,   9, 2, 0, 1'b1,   1};

        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_s0 = '0;
        req_a1 = '0; req_b1 = '0; req_s1 = '0;
        do_reset();
        tick();
        tick();
        check("rst_req_ready", 16'(req_ready), 16'd0);
        check("rst_resp_valid", 16'(resp_valid), 16'd0);
        check("rst_resp_data", 16'(resp_data), 16'd0);
        check("rst_alu_a", 16'(alu_a), 16'd0);
        check("rst_alu_s", 16'(alu_s), 16'd0);
`ifdef ALU_SHARE_STATS_EN
        check("rst_cnt0", grant_cnt0, 16'd0);
        check("rst_cnt1", grant_cnt1, 16'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Test-plan vectors with hand-computed results
        foreach (vecs[i]) begin
            op(vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].s0,
               vecs[i].a1, vecs[i].b1, vecs[i].s1,
               vecs[i].stall, vecs[i].eg, vecs[i].ed);
        end
        req_valid = 2'b00;
        tick();

`ifdef ALU_SHARE_STATS_EN
        check("cnt0", grant_cnt0, 16'(m_cnt0));
        check("cnt1", grant_cnt1, 16'(m_cnt1));
`endif

        // Reset during EXEC drops the transaction
        req_valid = 2'b01;
        req_a0 = 8'd255; req_b0 = 8'd255; req_s0 = 8'd1;
        tick();
        check("pre_rst_alu_a", 16'(alu_a), 16'd255);
        do_reset();
        #1;
        check("midrst_resp_valid", 16'(resp_valid), 16'd0);
        check("midrst_alu_a", 16'(alu_a), 16'd0);
        check("midrst_alu_b", 16'(alu_b), 16'd0);
        check("midrst_alu_s", 16'(alu_s), 16'd0);
        check("midrst_req_ready", 16'(req_ready), 16'd0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_resp", 16'(resp_valid), 16'd0);
        end
`ifdef ALU_SHARE_STATS_EN
        check("post_rst_cnt0", grant_cnt0, 16'd0);
`endif
        op(2'b11, 10, 12, 1, 24, 30, 0, 0, 1'b0, 254);

        // Randomized traffic against the transaction model
        for (int t = 0; t < 60; t++) begin
            rv  = 2'($urandom_range(1, 3));
            ra0 = 8'($urandom); rb0 = 8'($urandom);
            rs0 = 8'($urandom_range(0, 4));
            ra1 = 8'($urandom); rb1 = 8'($urandom);
            rs1 = 8'($urandom_range(0, 4));
            rg  = (rv == 2'b11) ? ~m_last : rv[1];
            op(rv, ra0, rb0, rs0, ra1, rb1, rs1,
               $urandom_range(0, 3), rg,
               rg ? alu_f(ra1, rb1, rs1) : alu_f(ra0, rb0, rs0));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 2'b00;
                tick();
            end
        end

`ifdef ALU_SHARE_STATS_EN
        check("rand_cnt0", grant_cnt0, 16'(m_cnt0));
        check("rand_cnt1", grant_cnt1, 16'(m_cnt1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencing controller that shares one combinational N-bit ALU (operands A, B, select s, result ALU_out) between two requesters.
- Arbitrates round-robin, registers the winner's operands onto the ALU inputs, captures the result, and returns it to the winning requester over a valid/ready response channel.
- Sits between two client blocks and the single ALU instance; the ALU itself is unchanged and lives outside this block.

Parameters:
- N, 8, operand, select and result width; must match the ALU's N.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester request accept.
- req_a0, req_b0, req_s0  in  N each  requester 0 operands and select.
- req_a1, req_b1, req_s1  in  N each  requester 1 operands and select.
- resp_valid  out  2  per-requester result valid.
- resp_ready  in  2  per-requester result accept.
- resp_data  out  N  result; meaningful only while some resp_valid bit is 1.
- alu_a, alu_b, alu_s  out  N each  registered drive to the ALU's A, B and s inputs.
- alu_out  in  N  ALU result, combinational from alu_a, alu_b, alu_s.

Behaviour:
- Reset values (while rst_n=0, asynchronously): state=IDLE, req_ready=0, resp_valid=0, resp_data=0, alu_a=alu_b=alu_s=0, last_grant=1 (so requester 0 wins the first tie). Any in-flight transaction is dropped, with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner: if both req_valid bits are set, the grant goes to the requester that is not last_grant; if one bit is set, that requester wins.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge where valid&ready: latch that requester's a/b/s into alu_a/alu_b/alu_s, store grant index g, last_grant<=g, go to EXEC.
  - No request: stay in IDLE.
- EXEC: alu_* are stable. On the edge, resp_data<=alu_out, resp_valid[g]<=1, go to RESP.
- RESP:
  - Hold resp_data and resp_valid[g] until resp_ready[g]=1.
  - On that edge: resp_valid<=0, go to IDLE.
  - resp_ready on the non-granted bit is ignored.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until accepted.
- Latency and throughput:
  - Request accept edge to resp_valid high: 2 cycles.
  - Minimum 3 cycles per operation (accept, EXEC, RESP with resp_ready already high).
- Arithmetic: the controller never modifies data. resp_data equals alu_out sampled in EXEC, truncated to N bits, with overflow wrapping in the ALU. Select s is passed through unchanged.
- alu_a/alu_b/alu_s keep their last values in IDLE and RESP; they are not cleared after an operation.
- Simultaneous events:
  - A new req_valid that arrives while in RESP waits in IDLE arbitration.
  - A requester may reassert req_valid in the cycle after its resp handshake.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1,...
- Reset mid-EXEC or mid-RESP: all outputs return to their reset values immediately. After reset release, the next grant goes to requester 0.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 16 bits, out.
  - Each counts accepted requests for its requester.
  - Counters saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: req0 a=5, b=23, s=0 held valid from IDLE -> req_ready[0] high that cycle; alu_a=5, alu_b=23, alu_s=0 next cycle; resp_valid[0]=1 with resp_data=28 two cycles after accept; resp_valid[1] stays 0.
- Wrap: req1 a=100, b=200, s=0 -> resp_data=44, resp_valid[1]=1; confirms N-bit truncation.
- Tie after reset: both valid (req0 10/12 s=1, req1 24/30 s=0) -> requester 0 granted first with alu_s=1; then requester 1, whose response is 54; continuous requests alternate 0,1,0,1 over 4 operations.
- Backpressure: resp_ready[0]=0 for 5 cycles in RESP -> resp_data and resp_valid[0] stable; req_ready=0 throughout; IDLE reached the cycle after resp_ready[0]=1.
- Reset mid-op: assert rst_n=0 during EXEC for req0 255/255 s=1 -> resp_valid=0 and alu_*=0 immediately; no response after release; the next tie grants requester 0.
- With ALU_SHARE_STATS_EN: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2; both read 0 after reset.
